// File: rtl/arith_unit_scheduler_29_if.sv
// Bundle of requester, response and arithmetic-unit signals for the
// two-requester arithmetic unit scheduler.
interface arith_unit_scheduler_29_if #(
  parameter int M = 32
);
  logic [1:0]     i_valid;
  logic [7:0]     i_op;
  logic [2*M-1:0] i_A;
  logic [2*M-1:0] i_B;
  logic [1:0]     o_ready;
  logic [1:0]     o_rsp_valid;
  logic [1:0]     i_rsp_ready;
  logic [M-1:0]   o_rsp_result;
  logic [3:0]     o_rsp_status;
  logic           o_rsp_err;
  logic [M-1:0]   o_alu_A;
  logic [M-1:0]   o_alu_B;
  logic [3:0]     o_alu_op;
  logic [M-1:0]   i_alu_result;
  logic [3:0]     i_alu_status;
  logic           o_busy;

  // Scheduler side.
  modport slave (
    input  i_valid, i_op, i_A, i_B, i_rsp_ready, i_alu_result, i_alu_status,
    output o_ready, o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err,
    output o_alu_A, o_alu_B, o_alu_op, o_busy
  );

  // Requesters plus arithmetic unit side.
  modport master (
    output i_valid, i_op, i_A, i_B, i_rsp_ready, i_alu_result, i_alu_status,
    input  o_ready, o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err,
    input  o_alu_A, o_alu_B, o_alu_op, o_busy
  );
endinterface

// File: rtl/arith_unit_scheduler_29.sv
// Arbitrates two requesters onto one fixed-latency arithmetic unit and routes
// the result back to the granted requester; opcodes 4..15 are rejected.
module arith_unit_scheduler_29 #(
  parameter int M   = 32,
  parameter int LAT = 1
) (
  input  logic                        clk,
  input  logic                        i_reset,
  arith_unit_scheduler_29_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic         last_grant_q;
  logic         id_q;
  logic [M-1:0] alu_a_q;
  logic [M-1:0] alu_b_q;
  logic [3:0]   alu_op_q;
  logic [M-1:0] result_q;
  logic [3:0]   status_q;
  logic         err_q;

  logic [1:0]   grant_d;
  logic [1:0]   ready;
  logic         xfer;
  logic         xfer_id;

  logic [3:0]   req_op [2];
  logic [M-1:0] req_a  [2];
  logic [M-1:0] req_b  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_op[gi] = bus.i_op[4*gi +: 4];
    assign req_a[gi]  = bus.i_A[M*gi +: M];
    assign req_b[gi]  = bus.i_B[M*gi +: M];
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_d = 2'b00;
    case (bus.i_valid)
      2'b01:   grant_d = 2'b01;
      2'b10:   grant_d = 2'b10;
      2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // Ready is gated by reset so it reads zero while reset is held.
  assign ready   = (i_reset && state_q == IDLE) ? grant_d : 2'b00;
  assign xfer    = |(bus.i_valid & ready);
  assign xfer_id = ready[1];

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 4'd0;
      result_q     <= '0;
      status_q     <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            id_q         <= xfer_id;
            last_grant_q <= xfer_id;
            if (req_op[xfer_id][3:2] == 2'b00) begin
              alu_op_q <= req_op[xfer_id];
              alu_a_q  <= req_a[xfer_id];
              alu_b_q  <= req_b[xfer_id];
              state_q  <= ISSUE;
            end else begin
              result_q <= '0;
              status_q <= 4'd0;
              err_q    <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= 4'(LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            result_q <= bus.i_alu_result;
            status_q <= bus.i_alu_status;
            err_q    <= 1'b0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready[id_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_rsp_valid  = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_status = status_q;
  assign bus.o_rsp_err    = err_q;
  assign bus.o_alu_A      = alu_a_q;
  assign bus.o_alu_B      = alu_b_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_arith_unit_scheduler_29.sv
// Self-checking bench: directed vector table, reset/abort sequences and
// randomized transactions against a transaction-level reference model.
module tb_arith_unit_scheduler_29;
  localparam int M   = 32;
  localparam int LAT = 1;

  typedef struct {
    logic [1:0]  mask;
    logic [3:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    int          hold;
    logic [1:0]  exp_g;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 clk = ~clk;

  arith_unit_scheduler_29_if #(.M(M)) bus();

  arith_unit_scheduler_29 #(.M(M), .LAT(LAT)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Arithmetic unit model: registered, one cycle latency.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        dz;
    dz = 1'b0;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    begin dz = (b == 32'd0); r = dz ? 32'd0 : a / b; end
      4'd3:    r = a * b;
      default: r = 32'd0;
    endcase
    return {r[31], 1'b0, dz, (r == 32'd0), r};
  endfunction

  logic [31:0] alu_res = 32'd0;
  logic [3:0]  alu_st  = 4'd0;
  always @(posedge clk) {alu_st, alu_res} <= alu_fn(bus.o_alu_op, bus.o_alu_A, bus.o_alu_B);
  assign bus.i_alu_result = alu_res;
  assign bus.i_alu_status = alu_st;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level model state.
  logic        m_last   = 1'b1;
  logic [31:0] m_alu_a  = 32'd0;
  logic [31:0] m_alu_b  = 32'd0;
  logic [3:0]  m_alu_op = 4'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] mask);
    if (mask == 2'b11) return m_last ? 2'b01 : 2'b10;
    return mask;
  endfunction

  function automatic vec_t mk(input logic [1:0] mask,
                              input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                              input int hold, input logic [1:0] g, input logic [31:0] res,
                              input logic [3:0] st, input logic err);
    vec_t v;
    v.mask = mask; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1; v.hold = hold;
    v.exp_g = g; v.exp_res = res; v.exp_st = st; v.exp_err = err;
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, bus.o_ready, 2'b00);
    chk({tag, "_rsp_valid"}, bus.o_rsp_valid, 2'b00);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_alu_A"}, bus.o_alu_A, 32'd0);
    chk({tag, "_alu_B"}, bus.o_alu_B, 32'd0);
    chk({tag, "_alu_op"}, bus.o_alu_op, 4'd0);
    chk({tag, "_result"}, bus.o_rsp_result, 32'd0);
    chk({tag, "_status"}, bus.o_rsp_status, 4'd0);
    chk({tag, "_err"}, bus.o_rsp_err, 1'b0);
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic run_txn(input vec_t v, input int idx);
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat;
    bus.i_valid     = v.mask;
    bus.i_op        = {v.op1, v.op0};
    bus.i_A         = {v.a1, v.a0};
    bus.i_B         = {v.b1, v.b0};
    bus.i_rsp_ready = 2'b00;
    #1;
    chk("o_ready_grant", bus.o_ready, v.exp_g);
    chk("o_busy_idle", bus.o_busy, 1'b0);
    sel = v.exp_g[1];
    op  = sel ? v.op1 : v.op0;
    a   = sel ? v.a1 : v.a0;
    b   = sel ? v.b1 : v.b0;
    @(posedge clk);
    m_last = sel;
    if (op < 4'd4) begin
      m_alu_op = op; m_alu_a = a; m_alu_b = b;
    end
    @(negedge clk);
    bus.i_op = 8'($urandom);
    bus.i_A  = {$urandom, $urandom};
    bus.i_B  = {$urandom, $urandom};
    lat = 1;
    while (bus.o_rsp_valid == 2'b00 && lat < 20) begin
      chk("o_ready_busy", bus.o_ready, 2'b00);
      chk("o_busy_run", bus.o_busy, 1'b1);
      chk("o_alu_op", bus.o_alu_op, m_alu_op);
      chk("o_alu_A", bus.o_alu_A, m_alu_a);
      chk("o_alu_B", bus.o_alu_B, m_alu_b);
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 64'(lat), (op < 4'd4) ? 64'(LAT + 2) : 64'd1);
    chk("alu_hold_resp", {bus.o_alu_op, bus.o_alu_A, bus.o_alu_B},
        {m_alu_op, m_alu_a, m_alu_b});
    chk("rsp_valid", bus.o_rsp_valid, v.exp_g);
    chk("rsp_result", bus.o_rsp_result, v.exp_res);
    chk("rsp_status", bus.o_rsp_status, v.exp_st);
    chk("rsp_err", bus.o_rsp_err, v.exp_err);
    for (int i = 0; i < v.hold; i++) begin
      bus.i_rsp_ready = ~v.exp_g;
      @(negedge clk);
      chk("hold_rsp_valid", bus.o_rsp_valid, v.exp_g);
      chk("hold_rsp_fields", {bus.o_rsp_result, bus.o_rsp_status, bus.o_rsp_err},
          {v.exp_res, v.exp_st, v.exp_err});
      chk("hold_o_ready", bus.o_ready, 2'b00);
      chk("hold_busy", bus.o_busy, 1'b1);
    end
    bus.i_rsp_ready = v.exp_g;
    @(negedge clk);
    chk("done_rsp_valid", bus.o_rsp_valid, 2'b00);
    chk("done_busy", bus.o_busy, 1'b0);
    $display("txn %0d: mask=%b grant=%b op=%0d A=%0h B=%0h result=%0h status=%b err=%b",
             idx, v.mask, v.exp_g, op, a, b, v.exp_res, v.exp_st, v.exp_err);
    bus.i_valid     = 2'b00;
    bus.i_rsp_ready = 2'b00;
  endtask

  vec_t vecs [8];

  initial begin
    vec_t        rv;
    logic [35:0] sr;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = mk(2'b11, 4'd2, 32'd100, 32'd5, 4'd0, 32'd7, 32'd9, 0, 2'b01, 32'd20, 4'b0000, 1'b0);
    vecs[1] = mk(2'b11, 4'd2, 32'd100, 32'd5, 4'd0, 32'd7, 32'd9, 1, 2'b10, 32'd16, 4'b0000, 1'b0);
    vecs[2] = mk(2'b11, 4'd1, 32'd5, 32'd5, 4'd0, 32'd7, 32'd9, 0, 2'b01, 32'd0, 4'b0001, 1'b0);
    vecs[3] = mk(2'b10, 4'd0, 32'd0, 32'd0, 4'd7, 32'd3, 32'd4, 5, 2'b10, 32'd0, 4'b0000, 1'b1);
    vecs[4] = mk(2'b01, 4'd3, 32'h8000_0000, 32'd1, 4'd0, 32'd0, 32'd0, 0, 2'b01,
                 32'h8000_0000, 4'b1000, 1'b0);
    vecs[5] = mk(2'b10, 4'd0, 32'd0, 32'd0, 4'd3, 32'd6, 32'd7, 2, 2'b10, 32'd42, 4'b0000, 1'b0);
    vecs[6] = mk(2'b11, 4'd2, 32'd1, 32'd0, 4'd1, 32'd9, 32'd2, 0, 2'b01, 32'd0, 4'b0011, 1'b0);
    vecs[7] = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd15, 32'd1, 32'd1, 1, 2'b10, 32'd0, 4'b0000, 1'b1);

    bus.i_valid = 2'b11; bus.i_op = 8'h22; bus.i_A = '1; bus.i_B = '1; bus.i_rsp_ready = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check_idle_zero("reset");
    end
    i_reset = 1'b1;
    #1;
    chk("first_tie_ready", bus.o_ready, 2'b01);
    $display("reset released: o_ready=%b", bus.o_ready);
    bus.i_valid = 2'b00; bus.i_rsp_ready = 2'b00;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Valid raised then dropped between edges must not start a transaction.
    bus.i_valid = 2'b01; bus.i_op = 8'h00;
    #2;
    bus.i_valid = 2'b00;
    @(negedge clk);
    chk("drop_valid_busy", bus.o_busy, 1'b0);
    chk("drop_valid_ready", bus.o_ready, 2'b00);
    $display("dropped valid: busy=%b", bus.o_busy);

    // Reset pulsed during WAIT abandons the operation.
    bus.i_valid = 2'b01; bus.i_op = 8'h02; bus.i_A = {32'd0, 32'hAAAA_AAAA}; bus.i_B = '0;
    @(negedge clk);
    bus.i_valid = 2'b00;
    chk("abort_issue_op", bus.o_alu_op, 4'd2);
    chk("abort_issue_A", bus.o_alu_A, 32'hAAAA_AAAA);
    @(negedge clk);
    chk("abort_wait_busy", bus.o_busy, 1'b1);
    i_reset = 1'b0;
    #1;
    check_idle_zero("abort");
    m_last = 1'b1; m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = 4'd0;
    #1;
    i_reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.o_rsp_valid, 2'b00);
      chk("abort_idle", bus.o_busy, 1'b0);
    end
    $display("reset during WAIT: no response after release");
    run_txn(mk(2'b11, 4'd0, 32'd1, 32'd2, 4'd1, 32'd9, 32'd4, 0, 2'b01, 32'd3, 4'b0000, 1'b0), 100);

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      rv.mask = 2'($urandom_range(1, 3));
      rv.op0 = 4'($urandom_range(0, 5)); rv.op1 = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) rv.op0 = 4'($urandom_range(6, 15));
      rv.a0 = $urandom; rv.a1 = $urandom;
      rv.b0 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      rv.b1 = $urandom;
      rv.hold = $urandom_range(0, 3);
      rv.exp_g = pick(rv.mask);
      rop = rv.exp_g[1] ? rv.op1 : rv.op0;
      ra  = rv.exp_g[1] ? rv.a1 : rv.a0;
      rb  = rv.exp_g[1] ? rv.b1 : rv.b0;
      if (rop < 4'd4) begin
        sr = alu_fn(rop, ra, rb);
        rv.exp_res = sr[31:0]; rv.exp_st = sr[35:32]; rv.exp_err = 1'b0;
      end else begin
        rv.exp_res = 32'd0; rv.exp_st = 4'd0; rv.exp_err = 1'b1;
      end
      run_txn(rv, 200 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arith_unit_scheduler_29.md
ARITH_UNIT_SCHEDULER_29 -- requirements
Module: arith_unit_scheduler_29

Interface
REQ-001 Parameter M, default 32: operand and result width.
REQ-002 Parameter LAT, default 1, legal 1..15: arithmetic unit latency in clk cycles.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-low.
REQ-005 i_valid  in  2  request valid; bit n belongs to requester n.
REQ-006 i_op  in  8  opcode; requester n uses bits [4n+3:4n].
REQ-007 i_A  in  2*M  operand A; requester n uses bits [n*M+M-1:n*M].
REQ-008 i_B  in  2*M  operand B; same packing as i_A.
REQ-009 o_ready  out  2  request accept; one-hot or zero.
REQ-010 o_rsp_valid  out  2  response valid for requester n; one-hot or zero.
REQ-011 i_rsp_ready  in  2  response accept from requester n.
REQ-012 o_rsp_result  out  M  response result.
REQ-013 o_rsp_status  out  4  response status.
REQ-014 o_rsp_err  out  1  opcode-rejected flag, valid with o_rsp_valid.
REQ-015 o_alu_A, o_alu_B  out  M each  operands to the arithmetic unit.
REQ-016 o_alu_op  out  4  opcode to the arithmetic unit.
REQ-017 i_alu_result  in  M, i_alu_status  in  4  arithmetic unit outputs.
REQ-018 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE, o_ready SHALL assert only for the selected requester:
- only one requester valid: that requester is selected;
- both valid: the requester other than last_grant is selected;
- none valid: o_ready = 0.
REQ-021 In ISSUE, WAIT and RESP, o_ready SHALL be 0.
REQ-022 A request SHALL transfer when i_valid[n] and o_ready[n] are both high at a rising edge.
REQ-023 On transfer, the block SHALL latch op, A, B and id = n, and set last_grant = n.
REQ-024 On transfer with op in 0..3, the next state SHALL be ISSUE.
REQ-025 On transfer with op in 4..15, the next state SHALL be RESP with result = 0, status = 0 and err = 1; the unit is not issued and o_alu_* stay unchanged.
REQ-026 In ISSUE, o_alu_A/B/op SHALL present the latched values.
REQ-027 o_alu_A/B/op SHALL hold stable through ISSUE and WAIT, and hold their last value otherwise.
REQ-028 ISSUE SHALL last exactly one cycle, load the wait counter with LAT, then go to WAIT.
REQ-029 WAIT SHALL last LAT cycles; the counter decrements each cycle.
REQ-030 At the closing edge of the last WAIT cycle, the block SHALL capture i_alu_result and i_alu_status with err = 0, then go to RESP.
REQ-031 In RESP, o_rsp_valid[id] SHALL be 1.
REQ-032 In RESP, o_rsp_result, o_rsp_status and o_rsp_err SHALL stay stable until i_rsp_ready[id] is 1 at a rising edge; the FSM then returns to IDLE.
REQ-033 i_rsp_ready[~id] SHALL be ignored.
REQ-034 Timing: a valid op gives o_rsp_valid LAT+2 cycles after the transfer edge; a rejected op gives it 1 cycle after.
REQ-035 No new request SHALL be accepted in the cycle the response completes.
REQ-036 Best-case throughput SHALL be one valid op per LAT+3 cycles.
REQ-037 Dropping i_valid before a transfer SHALL have no effect.
REQ-038 Changing i_op, i_A or i_B after a transfer SHALL not affect the operation in flight.
REQ-039 o_busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-040 While i_reset = 0, the block SHALL immediately force:
- state = IDLE, counter = 0, last_grant = 1;
- every output = 0, including o_alu_A/B/op and all response fields.
REQ-041 Reset in ISSUE, WAIT or RESP SHALL abandon the transaction with no response after release.
REQ-042 The first tie after reset SHALL go to requester 0.

Verification
(Bench uses the sync_arith_unit_29 model with LAT = 1.)
REQ-043 Reset sequence -> all outputs 0 while i_reset = 0; o_ready = 2'b01 on the first cycle after release with i_valid = 2'b11.
REQ-044 Requester 0: op 4'b0010, A = 100, B = 5 -> o_alu_op = 4'b0010 in ISSUE; o_rsp_valid = 2'b01 three cycles after transfer; result = 20, err = 0.
REQ-045 Both requesters held valid for three transactions -> grant order 0, 1, 0; each response routed only to its own o_rsp_valid bit.
REQ-046 Requester 1: op 4'b0111 -> o_alu_* unchanged; o_rsp_valid = 2'b10 next cycle; result = 0, status = 0, err = 1.
REQ-047 i_rsp_ready held 0 for 5 cycles in RESP, requester 1 valid -> response fields stable, o_ready = 0, o_busy = 1; completes on the edge where i_rsp_ready[id] = 1.
REQ-048 A = 0xAAAAAAAA, B = 0, op 4'b0010, i_reset pulsed low during WAIT -> all outputs 0 immediately; no response after release; next request serviced normally.
